// File: rtl/turf_hold_scheduler.sv
// Allocates per-SURF analog hold buffers on L1 triggers, drives the replicated HOLD bus and queues
// held buffers for readout. Optional dead-time/drop counters built under TURF_DEADTIME_CNT_EN.
module turf_hold_scheduler #(
  parameter int unsigned NUM_SURFS    = 12,
  parameter int unsigned NUM_HOLD     = 4,
  parameter int unsigned HOLD_DELAY   = 2,
  parameter int unsigned REARM_CYCLES = 3,
  localparam int unsigned IdxW        = (NUM_HOLD > 1) ? $clog2(NUM_HOLD) : 1
) (
  input  logic                          CLK33,
  input  logic                          RST,
  input  logic                          TRIG,
  output logic                          TRIG_ACC,
  output logic                          TRIG_DROP,
  output logic [NUM_HOLD*NUM_SURFS-1:0] HOLD,
  output logic                          DEAD,
  output logic                          RD_VALID,
  output logic [IdxW-1:0]               RD_BUF,
  input  logic                          RD_ACK,
  output logic [31:0]                   DEAD_CNT,
  output logic [15:0]                   DROP_CNT
);

  localparam int unsigned CntW = $clog2(NUM_HOLD + 1);

  typedef enum logic [1:0] {StFree, StArming, StHeld, StRearm} buf_state_e;

  buf_state_e      state_q [NUM_HOLD];
  buf_state_e      state_d [NUM_HOLD];
  logic [3:0]      cnt_q   [NUM_HOLD];
  logic [3:0]      cnt_d   [NUM_HOLD];
  logic [IdxW-1:0] fifo_q  [NUM_HOLD];
  logic [IdxW-1:0] fifo_d  [NUM_HOLD];
  logic [IdxW-1:0] ptr_q, ptr_d, head_q, head_d, tail_q, tail_d;
  logic [IdxW-1:0] push_idx_q, push_idx_d, alloc_idx;
  logic [CntW-1:0] count_q, count_d;
  logic            acc_q, acc_d, drop_q, drop_d, push_q, push_d;
  logic            alloc_found, alloc, pop;
  logic [NUM_HOLD-1:0] free_vec;

  function automatic logic [IdxW-1:0] inc_idx(input logic [IdxW-1:0] i);
    return (i == IdxW'(NUM_HOLD - 1)) ? '0 : i + 1'b1;
  endfunction

  always_comb begin
    for (int b = 0; b < NUM_HOLD; b++) free_vec[b] = (state_q[b] == StFree);
  end

  assign DEAD      = ~|free_vec;
  assign RD_VALID  = (count_q != '0);
  assign RD_BUF    = fifo_q[head_q];
  assign pop       = RD_ACK & RD_VALID;
  assign TRIG_ACC  = acc_q;
  assign TRIG_DROP = drop_q;

  // First FREE buffer at or above the pointer, wrapping modulo NUM_HOLD.
  always_comb begin
    logic [IdxW:0] sum;
    alloc_found = 1'b0;
    alloc_idx   = '0;
    sum         = '0;
    for (int i = 0; i < NUM_HOLD; i++) begin
      sum = {1'b0, ptr_q} + (IdxW+1)'(i);
      if (sum >= (IdxW+1)'(NUM_HOLD)) sum = sum - (IdxW+1)'(NUM_HOLD);
      if (!alloc_found && free_vec[sum[IdxW-1:0]]) begin
        alloc_found = 1'b1;
        alloc_idx   = sum[IdxW-1:0];
      end
    end
  end

  assign alloc  = TRIG & alloc_found;
  assign acc_d  = alloc;
  assign drop_d = TRIG & ~alloc_found;
  assign ptr_d  = alloc ? inc_idx(alloc_idx) : ptr_q;

  // Per-buffer lifecycle; with a constant delay at most one buffer reaches HELD per edge.
  always_comb begin
    push_d     = 1'b0;
    push_idx_d = '0;
    for (int b = 0; b < NUM_HOLD; b++) begin
      state_d[b] = state_q[b];
      cnt_d[b]   = cnt_q[b];
      unique case (state_q[b])
        StFree: begin
          if (alloc && alloc_idx == IdxW'(b)) begin
            if (HOLD_DELAY == 0) begin
              state_d[b] = StHeld;
              push_d     = 1'b1;
              push_idx_d = IdxW'(b);
            end else begin
              state_d[b] = StArming;
              cnt_d[b]   = 4'(HOLD_DELAY);
            end
          end
        end
        StArming: begin
          if (cnt_q[b] <= 4'd1) begin
            state_d[b] = StHeld;
            cnt_d[b]   = '0;
            push_d     = 1'b1;
            push_idx_d = IdxW'(b);
          end else begin
            cnt_d[b] = cnt_q[b] - 4'd1;
          end
        end
        StHeld: begin
          if (pop && RD_BUF == IdxW'(b)) begin
            state_d[b] = StRearm;
            cnt_d[b]   = 4'(REARM_CYCLES);
          end
        end
        StRearm: begin
          if (cnt_q[b] <= 4'd1) begin
            state_d[b] = StFree;
            cnt_d[b]   = '0;
          end else begin
            cnt_d[b] = cnt_q[b] - 4'd1;
          end
        end
      endcase
    end
  end

  // Pushes land one edge after HOLD rises so RD_VALID follows the push by a cycle.
  always_comb begin
    for (int i = 0; i < NUM_HOLD; i++) fifo_d[i] = fifo_q[i];
    tail_d = tail_q;
    head_d = head_q;
    if (push_q) begin
      fifo_d[tail_q] = push_idx_q;
      tail_d         = inc_idx(tail_q);
    end
    if (pop) head_d = inc_idx(head_q);
    count_d = count_q + CntW'(push_q) - CntW'(pop);
  end

  always_comb begin
    HOLD = '0;
    for (int s = 0; s < NUM_SURFS; s++) begin
      for (int b = 0; b < NUM_HOLD; b++) HOLD[NUM_HOLD*s+b] = (state_q[b] == StHeld);
    end
  end

  always_ff @(posedge CLK33) begin
    if (RST) begin
      for (int b = 0; b < NUM_HOLD; b++) begin
        state_q[b] <= StFree;
        cnt_q[b]   <= '0;
        fifo_q[b]  <= '0;
      end
      ptr_q      <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      push_q     <= 1'b0;
      push_idx_q <= '0;
      acc_q      <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      for (int b = 0; b < NUM_HOLD; b++) begin
        state_q[b] <= state_d[b];
        cnt_q[b]   <= cnt_d[b];
        fifo_q[b]  <= fifo_d[b];
      end
      ptr_q      <= ptr_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      push_q     <= push_d;
      push_idx_q <= push_idx_d;
      acc_q      <= acc_d;
      drop_q     <= drop_d;
    end
  end

`ifdef TURF_DEADTIME_CNT_EN
  logic [31:0] dead_cnt_q, dead_cnt_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    dead_cnt_d = dead_cnt_q + 32'(DEAD);
    drop_cnt_d = drop_cnt_q;
    if (drop_d && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
  end

  always_ff @(posedge CLK33) begin
    if (RST) begin
      dead_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      dead_cnt_q <= dead_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign DEAD_CNT = dead_cnt_q;
  assign DROP_CNT = drop_cnt_q;
`else
  assign DEAD_CNT = '0;
  assign DROP_CNT = '0;
`endif

endmodule

// File: tb/tb_turf_hold_scheduler.sv
// Directed bench for turf_hold_scheduler with default parameters; counter checks follow
// TURF_DEADTIME_CNT_EN.
module tb_turf_hold_scheduler;

`ifdef TURF_DEADTIME_CNT_EN
  localparam bit CntEn = 1'b1;
`else
  localparam bit CntEn = 1'b0;
`endif

  localparam logic [47:0] HoldB0  = 48'h111111111111;
  localparam logic [47:0] HoldAll = 48'hFFFFFFFFFFFF;
  localparam logic [47:0] HoldNo0 = 48'hEEEEEEEEEEEE;
  localparam logic [47:0] Hold012 = 48'h777777777777;

  logic        clk, rst, trig, rd_ack;
  logic        trig_acc, trig_drop, dead, rd_valid;
  logic [47:0] hold;
  logic [1:0]  rd_buf;
  logic [31:0] dead_cnt;
  logic [15:0] drop_cnt;

  int n_checks = 0;
  int n_errors = 0;

  turf_hold_scheduler u_dut (
    .CLK33     (clk),
    .RST       (rst),
    .TRIG      (trig),
    .TRIG_ACC  (trig_acc),
    .TRIG_DROP (trig_drop),
    .HOLD      (hold),
    .DEAD      (dead),
    .RD_VALID  (rd_valid),
    .RD_BUF    (rd_buf),
    .RD_ACK    (rd_ack),
    .DEAD_CNT  (dead_cnt),
    .DROP_CNT  (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [1:0] order [4];
    rst = 1'b1; trig = 1'b0; rd_ack = 1'b0;
    tick();
    tick();
    check_eq("rst_hold", 64'(hold), 64'h0);
    check_eq("rst_acc", 64'(trig_acc), 64'h0);
    check_eq("rst_drop", 64'(trig_drop), 64'h0);
    check_eq("rst_valid", 64'(rd_valid), 64'h0);
    check_eq("rst_buf", 64'(rd_buf), 64'h0);
    check_eq("rst_dead", 64'(dead), 64'h0);
    rst = 1'b0;

    // Single trigger latency
    trig = 1'b1; tick(); trig = 1'b0;
    check_eq("t1_acc", 64'(trig_acc), 64'h1);
    check_eq("t1_hold_n1", 64'(hold), 64'h0);
    tick();
    check_eq("t1_hold_n2", 64'(hold), 64'h0);
    tick();
    check_eq("t1_hold_n3", 64'(hold), 64'(HoldB0));
    check_eq("t1_valid_n3", 64'(rd_valid), 64'h0);
    tick();
    check_eq("t1_valid_n4", 64'(rd_valid), 64'h1);
    check_eq("t1_buf_n4", 64'(rd_buf), 64'h0);
    rd_ack = 1'b1; tick(); rd_ack = 1'b0;
    check_eq("t1_hold_rel", 64'(hold), 64'h0);
    check_eq("t1_valid_rel", 64'(rd_valid), 64'h0);

    // Fill all four buffers then drop a fifth trigger
    do_reset();
    trig = 1'b1;
    repeat (4) tick();
    check_eq("t2_dead", 64'(dead), 64'h1);
    tick(); trig = 1'b0;
    check_eq("t2_drop", 64'(trig_drop), 64'h1);
    check_eq("t2_acc", 64'(trig_acc), 64'h0);
    check_eq("t2_dropcnt", 64'(drop_cnt), CntEn ? 64'h1 : 64'h0);
    repeat (3) tick();
    check_eq("t2_valid", 64'(rd_valid), 64'h1);
    check_eq("t2_head", 64'(rd_buf), 64'h0);
    check_eq("t2_hold_all", 64'(hold), 64'(HoldAll));
    check_eq("t2_deadcnt", 64'(dead_cnt), CntEn ? 64'd4 : 64'd0);

    // Release buffer 0, rearm window, wrap allocation
    rd_ack = 1'b1; tick(); rd_ack = 1'b0;
    check_eq("t3_hold_no0", 64'(hold), 64'(HoldNo0));
    check_eq("t3_head1", 64'(rd_buf), 64'h1);
    tick(); tick();
    check_eq("t3_dead_rearm", 64'(dead), 64'h1);
    trig = 1'b1; tick(); trig = 1'b0;
    check_eq("t3_drop_rearm", 64'(trig_drop), 64'h1);
    check_eq("t3_dead_free", 64'(dead), 64'h0);
    check_eq("t3_dropcnt", 64'(drop_cnt), CntEn ? 64'd2 : 64'd0);
    trig = 1'b1; tick(); trig = 1'b0;
    check_eq("t3_acc_wrap", 64'(trig_acc), 64'h1);
    check_eq("t3_dead_again", 64'(dead), 64'h1);
    check_eq("t3_deadcnt", 64'(dead_cnt), CntEn ? 64'd8 : 64'd0);
    repeat (3) tick();
    order = '{2'd1, 2'd2, 2'd3, 2'd0};
    for (int k = 0; k < 4; k++) begin
      check_eq($sformatf("t3_order%0d", k), 64'(rd_buf), 64'(order[k]));
      check_eq($sformatf("t3_ordv%0d", k), 64'(rd_valid), 64'h1);
      rd_ack = 1'b1; tick(); rd_ack = 1'b0;
    end
    check_eq("t3_empty", 64'(rd_valid), 64'h0);

    // Same-cycle ack and trigger with only buffer 2 free
    do_reset();
    trig = 1'b1; repeat (4) tick(); trig = 1'b0;
    repeat (4) tick();
    rd_ack = 1'b1; repeat (3) tick(); rd_ack = 1'b0;
    repeat (3) tick();
    trig = 1'b1; repeat (2) tick(); trig = 1'b0;
    repeat (3) tick();
    check_eq("t4_head3", 64'(rd_buf), 64'h3);
    check_eq("t4_dead_pre", 64'(dead), 64'h0);
    rd_ack = 1'b1; trig = 1'b1; tick(); rd_ack = 1'b0; trig = 1'b0;
    check_eq("t4_acc", 64'(trig_acc), 64'h1);
    check_eq("t4_dead", 64'(dead), 64'h1);
    repeat (2) tick();
    check_eq("t4_hold012", 64'(hold), 64'(Hold012));
    tick();
    for (int k = 0; k < 3; k++) begin
      check_eq($sformatf("t4_order%0d", k), 64'(rd_buf), 64'(k));
      rd_ack = 1'b1; tick(); rd_ack = 1'b0;
    end

    // Reset with three held, one arming and a drop counted
    do_reset();
    trig = 1'b1; repeat (5) tick(); trig = 1'b0;
    check_eq("t5_hold_pre", 64'(hold), 64'(Hold012));
    check_eq("t5_drop_pre", 64'(trig_drop), 64'h1);
    rst = 1'b1; tick(); rst = 1'b0;
    check_eq("t5_hold", 64'(hold), 64'h0);
    check_eq("t5_valid", 64'(rd_valid), 64'h0);
    check_eq("t5_dead", 64'(dead), 64'h0);
    check_eq("t5_deadcnt", 64'(dead_cnt), 64'h0);
    check_eq("t5_dropcnt", 64'(drop_cnt), 64'h0);

    // Spurious ack on an empty queue
    rd_ack = 1'b1; tick(); rd_ack = 1'b0;
    check_eq("t6_valid", 64'(rd_valid), 64'h0);
    check_eq("t6_hold", 64'(hold), 64'h0);
    check_eq("t6_dead", 64'(dead), 64'h0);
    trig = 1'b1; tick(); trig = 1'b0;
    check_eq("t6_acc", 64'(trig_acc), 64'h1);
    repeat (2) tick();
    check_eq("t6_hold_b0", 64'(hold), 64'(HoldB0));
    check_eq("t6_deadcnt", 64'(dead_cnt), 64'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
